// File: rtl/seg7_scan_decoder_pkg.sv
// Shared constants for the multiplexed 7-segment scan decoder and the CPU display driver.
// Segment patterns are listed a..g from MSB to LSB with 1 meaning lit.
package seg7_scan_decoder_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_SEGS   = 7;
    localparam int DIGIT_W    = 4;

    localparam logic [NUM_SEGS-1:0] SEG_PAT_0     = 7'b1111110;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_1     = 7'b0110000;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_2     = 7'b1101101;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_3     = 7'b1111001;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_4     = 7'b0110011;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_5     = 7'b1011011;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_6     = 7'b1011111;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_7     = 7'b1110000;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_8     = 7'b1111111;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_9     = 7'b1111011;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_A     = 7'b1110111;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_B     = 7'b0011111;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_C     = 7'b1001110;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_D     = 7'b0111101;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_E     = 7'b1001111;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_F     = 7'b1000111;
    localparam logic [NUM_SEGS-1:0] SEG_PAT_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_e;

    // True when exactly one active-low enable is asserted.
    function automatic logic is_one_low(input logic [NUM_DIGITS-1:0] an);
        int zeros;
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_pattern_decode.sv
// Combinational lookup of a lit-high segment pattern into its hex value.
// Blank decodes as a legal pattern with value 0; anything outside the table is flagged invalid.
module seg7_pattern_decode
    import seg7_scan_decoder_pkg::*;
(
    input  logic [NUM_SEGS-1:0] seg_lit_i,
    output logic [DIGIT_W-1:0]  value_o,
    output logic                blank_o,
    output logic                valid_o
);

    always_comb begin
        value_o = '0;
        blank_o = 1'b0;
        valid_o = 1'b1;
        case (seg_lit_i)
            SEG_PAT_0:     value_o = 4'h0;
            SEG_PAT_1:     value_o = 4'h1;
            SEG_PAT_2:     value_o = 4'h2;
            SEG_PAT_3:     value_o = 4'h3;
            SEG_PAT_4:     value_o = 4'h4;
            SEG_PAT_5:     value_o = 4'h5;
            SEG_PAT_6:     value_o = 4'h6;
            SEG_PAT_7:     value_o = 4'h7;
            SEG_PAT_8:     value_o = 4'h8;
            SEG_PAT_9:     value_o = 4'h9;
            SEG_PAT_A:     value_o = 4'hA;
            SEG_PAT_B:     value_o = 4'hB;
            SEG_PAT_C:     value_o = 4'hC;
            SEG_PAT_D:     value_o = 4'hD;
            SEG_PAT_E:     value_o = 4'hE;
            SEG_PAT_F:     value_o = 4'hF;
            SEG_PAT_BLANK: blank_o = 1'b1;
            default:       valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Sniffs a multiplexed 4-digit 7-segment bus and recovers the displayed hex digits once
// each digit's pattern has been stable for STABLE_CYCLES sampled cycles.
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SEGS-1:0]             seg_in,
    input  logic [NUM_DIGITS-1:0]           an_in,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   digits_o,
    output logic [NUM_DIGITS-1:0]           digit_vld_o,
    output logic [NUM_DIGITS-1:0]           blank_o,
    output logic                            frame_o,
    output logic                            an_err_o,
    output logic                            seg_err_o
);

    localparam int PAT_W = NUM_SEGS + NUM_DIGITS;
    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [NUM_SEGS-1:0]           seg_q, seg_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic [PAT_W-1:0]              prev_q, prev_d;
    scan_state_e                   state_q, state_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]         vld_q, vld_d;
    logic [NUM_DIGITS-1:0]         blank_q, blank_d;
    logic [NUM_DIGITS-1:0]         seen_q, seen_d;
    logic                          frame_q, frame_d;
    logic                          an_err_q, an_err_d;
    logic                          seg_err_q, seg_err_d;

    logic [PAT_W-1:0]   cur_pat;
    logic               pat_chg;
    logic               one_low;
    logic               multi_low;
    logic               prev_multi;
    logic [1:0]         dig_idx;
    logic               accept;
    logic [DIGIT_W-1:0] dec_value;
    logic               dec_blank;
    logic               dec_valid;

    // The bus is active-low; the decoder works on lit-high patterns.
    seg7_pattern_decode u_decode (
        .seg_lit_i (~seg_q),
        .value_o   (dec_value),
        .blank_o   (dec_blank),
        .valid_o   (dec_valid)
    );

    assign cur_pat    = {seg_q, an_q};
    assign pat_chg    = (cur_pat != prev_q);
    assign one_low    = is_one_low(an_q);
    assign multi_low  = (an_q != '1) && !one_low;
    assign prev_multi = (prev_q[NUM_DIGITS-1:0] != '1) && !is_one_low(prev_q[NUM_DIGITS-1:0]);

    always_comb begin
        dig_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) dig_idx = 2'(i);
        end
    end

    always_comb begin
        seg_d     = seg_in;
        an_d      = an_in;
        prev_d    = cur_pat;
        state_d   = state_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        vld_d     = vld_q;
        blank_d   = blank_q;
        an_err_d  = 1'b0;
        seg_err_d = 1'b0;
        accept    = 1'b0;
        // A completed frame is reported one cycle later and the tracker restarts empty.
        frame_d   = (seen_q == '1);
        seen_d    = (seen_q == '1) ? '0 : seen_q;

        if (an_q == '1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (multi_low) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            an_err_d = !prev_multi;
        end else if (pat_chg || (state_q == ST_SETTLE)) begin
            state_d = ST_SETTLE;
            if (pat_chg) begin
                cnt_d = 8'd1;
            end else if (cnt_q < STABLE_CNT) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = STABLE_CNT;
            end
            if (cnt_d == STABLE_CNT) begin
                accept  = 1'b1;
                state_d = ST_HELD;
            end
        end

        if (accept) begin
            if (dec_valid) begin
                digits_d[{dig_idx, 2'b00} +: DIGIT_W] = dec_blank ? '0 : dec_value;
                vld_d[dig_idx]   = 1'b1;
                blank_d[dig_idx] = dec_blank;
                seen_d[dig_idx]  = 1'b1;
            end else begin
                seg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q     <= '1;
            an_q      <= '1;
            prev_q    <= '1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            digits_q  <= '0;
            vld_q     <= '0;
            blank_q   <= '0;
            seen_q    <= '0;
            frame_q   <= 1'b0;
            an_err_q  <= 1'b0;
            seg_err_q <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            an_q      <= an_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            vld_q     <= vld_d;
            blank_q   <= blank_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            an_err_q  <= an_err_d;
            seg_err_q <= seg_err_d;
        end
    end

    assign digits_o    = digits_q;
    assign digit_vld_o = vld_q;
    assign blank_o     = blank_q;
    assign frame_o     = frame_q;
    assign an_err_o    = an_err_q;
    assign seg_err_o   = seg_err_q;

endmodule
